// File: rtl/demux_dispatch_if.sv
// Request/select bundle between a dispatch client and demux_dispatch.
// The stat_cnt member exists only when DEMUX_DISPATCH_STATS_EN is defined.
interface demux_dispatch_if #(
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_dest;
   logic [HOLD_W-1:0] req_len;
   logic              a;
   logic              b;
   logic              en;
   logic              busy;
   logic [CNT_W-1:0]  fifo_count;

`ifdef DEMUX_DISPATCH_STATS_EN
   logic [31:0]       stat_cnt;

   modport slave (
      input  req_valid, req_dest, req_len,
      output req_ready, a, b, en, busy, fifo_count, stat_cnt
   );

   modport master (
      output req_valid, req_dest, req_len,
      input  req_ready, a, b, en, busy, fifo_count, stat_cnt
   );
`else
   modport slave (
      input  req_valid, req_dest, req_len,
      output req_ready, a, b, en, busy, fifo_count
   );

   modport master (
      output req_valid, req_dest, req_len,
      input  req_ready, a, b, en, busy, fifo_count
   );
`endif
endinterface

// File: rtl/demux_dispatch.sv
// Queued sequencer driving glitch-free a/b/en for a 1-to-4 demux.
// Optional per-line dispatch counters are enabled with DEMUX_DISPATCH_STATS_EN.
module demux_dispatch #(
   parameter int DEPTH  = 4,
   parameter int HOLD_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   demux_dispatch_if.slave  bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = HOLD_W + 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic               full_s;
   logic               empty_s;
   logic               push_s;
   logic               pop_s;
   logic [ENTRY_W-1:0] head_s;
   logic [1:0]         head_dest_s;
   logic [HOLD_W-1:0]  head_len_s;
   logic [HOLD_W-1:0]  load_len_s;

   state_t             state_r;
   state_t             state_next_s;
   logic [HOLD_W-1:0]  hold_r;
   logic [HOLD_W-1:0]  hold_next_s;
   logic               a_r;
   logic               a_next_s;
   logic               b_r;
   logic               b_next_s;
   logic               en_r;
   logic               en_next_s;
   logic               done_s;

   assign full_s      = (count_r == CNT_W'(DEPTH));
   assign empty_s     = (count_r == CNT_W'(1'b0));
   assign push_s      = bus.req_valid && !full_s;
   assign head_s      = mem_r[rd_ptr_r];
   assign head_dest_s = head_s[ENTRY_W-1 -: 2];
   assign head_len_s  = head_s[HOLD_W-1:0];
   // A zero hold length still gives a one-cycle enable pulse.
   assign load_len_s  = (head_len_s == HOLD_W'(1'b0)) ? HOLD_W'(1'b1) : head_len_s;

   // FIFO storage write; contents need no reset because count gates reads.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {bus.req_dest, bus.req_len};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= PTR_W'(1'b0);
         rd_ptr_r <= PTR_W'(1'b0);
         count_r  <= CNT_W'(1'b0);
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Dispatch sequencing: next state, hold counter and select/enable values.
   always_comb begin
      state_next_s = state_r;
      hold_next_s  = hold_r;
      a_next_s     = a_r;
      b_next_s     = b_r;
      en_next_s    = en_r;
      pop_s        = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         ST_IDLE, ST_GAP: begin
            en_next_s = 1'b0;
            if (!empty_s) begin
               pop_s                  = 1'b1;
               {b_next_s, a_next_s}   = head_dest_s;
               hold_next_s            = load_len_s;
               state_next_s           = ST_SETUP;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            en_next_s    = 1'b1;
            state_next_s = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (hold_r == HOLD_W'(1'b1)) begin
               en_next_s    = 1'b0;
               done_s       = 1'b1;
               state_next_s = ST_GAP;
            end else begin
               en_next_s    = 1'b1;
               hold_next_s  = hold_r - HOLD_W'(1'b1);
               state_next_s = ST_ACTIVE;
            end
         end
         default: begin
            en_next_s    = 1'b0;
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset drops en immediately and abandons the transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         hold_r  <= HOLD_W'(1'b0);
         a_r     <= 1'b0;
         b_r     <= 1'b0;
         en_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         hold_r  <= hold_next_s;
         a_r     <= a_next_s;
         b_r     <= b_next_s;
         en_r    <= en_next_s;
      end
   end

   assign bus.req_ready  = !full_s;
   assign bus.a          = a_r;
   assign bus.b          = b_r;
   assign bus.en         = en_r;
   assign bus.busy       = (state_r != ST_IDLE);
   assign bus.fifo_count = count_r;

`ifdef DEMUX_DISPATCH_STATS_EN
   logic [7:0] stat_r [4];

   // Saturating completed-dispatch counters indexed by the held select lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            stat_r[i] <= 8'd0;
         end
      end else if (done_s && (stat_r[{b_r, a_r}] != 8'hFF)) begin
         stat_r[{b_r, a_r}] <= stat_r[{b_r, a_r}] + 8'd1;
      end
   end

   assign bus.stat_cnt = {stat_r[3], stat_r[2], stat_r[1], stat_r[0]};
`endif

endmodule
